// File: rtl/debug_reg_dumper.sv
// Scans the 32 architectural registers through the datapath debug port and streams them out
// as big-endian 8N1 UART bytes. Define DEBUG_DUMP_PC_EN to append the fetch PC as a 33rd word.
module debug_reg_dumper #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dbg_data,
  input  logic [31:0] pc_in,
  output logic [4:0]  dbg_sel,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W = 32;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef DEBUG_DUMP_PC_EN
  localparam logic [5:0] LAST_WORD = 6'd32;
`else
  localparam logic [5:0] LAST_WORD = 6'd31;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CAPTURE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_FINISH
  } state_t;

  // Byte idx 0 is the most significant byte: words leave big-endian.
  function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = word[31:24];
      2'd1:    byte_of = word[23:16];
      2'd2:    byte_of = word[15:8];
      default: byte_of = word[7:0];
    endcase
  endfunction

  function automatic logic [4:0] sel_for(input logic [5:0] w);
    sel_for = (w > 6'd31) ? 5'd31 : w[4:0];
  endfunction

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [1:0]          byte_q, byte_d;
  logic [5:0]          word_q, word_d;
  logic [DATA_W-1:0]   word_buf_q, word_buf_d;
  logic [7:0]          shift_q, shift_d;
  logic [4:0]          sel_q, sel_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   cap_word;
  logic                baud_end;

`ifdef DEBUG_DUMP_PC_EN
  assign cap_word = (word_q == 6'd32) ? pc_in : dbg_data;
`else
  logic unused_pc;
  assign unused_pc = ^pc_in;
  assign cap_word  = dbg_data;
`endif

  assign baud_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    word_d     = word_q;
    word_buf_d = word_buf_q;
    shift_d    = shift_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          busy_d  = 1'b1;
          word_d  = 6'd0;
          sel_d   = 5'd0;
        end
      end

      // dbg_sel already points at the word; this cycle lets the register-file read settle.
      S_SELECT: state_d = S_CAPTURE;

      S_CAPTURE: begin
        word_buf_d = cap_word;
        byte_d     = 2'd0;
        bit_d      = 3'd0;
        baud_d     = '0;
        shift_d    = byte_of(cap_word, 2'd0);
        state_d    = S_TX_START;
      end

      S_TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_TX_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = byte_of(word_buf_q, byte_q + 2'd1);
            state_d = S_TX_START;
          end else if (word_q != LAST_WORD) begin
            word_d  = word_q + 6'd1;
            sel_d   = sel_for(word_q + 6'd1);
            state_d = S_SELECT;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // tx follows the next state so the line register stays aligned with state_q.
    if (state_d == S_TX_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_TX_DATA) begin
      tx_d = shift_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      word_q     <= 6'd0;
      word_buf_q <= '0;
      shift_q    <= 8'd0;
      sel_q      <= 5'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      word_q     <= word_d;
      word_buf_q <= word_buf_d;
      shift_q    <= shift_d;
      sel_q      <= sel_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dbg_sel = sel_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Directed bench for debug_reg_dumper with CLKS_PER_BIT=4 and a stub register file
// returning 32'h1000_0000 + index; a background UART receiver decodes the tx line.
module tb_debug_reg_dumper;

  localparam int CPB = 4;
`ifdef DEBUG_DUMP_PC_EN
  localparam int WORDS = 33;
`else
  localparam int WORDS = 32;
`endif
  localparam int BUSY_LEN = WORDS * (2 + 40 * CPB);
  localparam logic [31:0] PC_VAL = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dbg_data;
  logic [31:0] pc_in = PC_VAL;
  logic [4:0]  dbg_sel;
  logic        tx, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dbg_data = 32'h1000_0000 + {27'd0, dbg_sel};

  debug_reg_dumper #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .start(start), .dbg_data(dbg_data), .pc_in(pc_in),
    .dbg_sel(dbg_sel), .tx(tx), .busy(busy), .done(done)
  );

  // UART receiver: samples mid-bit on negedges, offset 0 = first cycle of the start bit.
  logic [7:0] rx_q[$];
  int         frame_err = 0;
  int         rx_cnt = 0;
  logic       rx_active = 1'b0;
  logic [7:0] rx_sh = 8'd0;

  always @(negedge clk) begin
    if (reset) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if ((rx_cnt + 1) >= 6 && (rx_cnt + 1) <= 34 && ((rx_cnt + 1) % 4) == 2)
        rx_sh[((rx_cnt + 1) - 6) / 4] <= tx;
      if ((rx_cnt + 1) == 38) begin
        rx_q.push_back(rx_sh);
        if (tx !== 1'b1) frame_err <= frame_err + 1;
      end
      if ((rx_cnt + 1) == 39) rx_active <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one dump from a start pulse; optional re-pulse of start and mid-dump reset.
  task automatic run_dump(input int repulse_at, input int reset_at, input bit check_sel);
    int cnt;
    int dones;
    int last_sel;
    int sel_log[$];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    cnt = 0;
    dones = 0;
    last_sel = -1;
    while (busy === 1'b1 && cnt < 20000) begin
      cnt++;
      if (done === 1'b1) dones++;
      if (int'(dbg_sel) != last_sel) begin
        sel_log.push_back(int'(dbg_sel));
        last_sel = int'(dbg_sel);
      end
      if (cnt == repulse_at) start = 1'b1;
      if (cnt == repulse_at + 1) start = 1'b0;
      if (cnt == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sel", {27'd0, dbg_sel}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("busy_len", cnt, BUSY_LEN);
    chk("done_during_busy", dones, 0);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("finish_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("done_fall", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_tx", {31'd0, tx}, 32'd1);
    if (check_sel) begin
      chk("sel_count", sel_log.size(), 32);
      for (int i = 0; i < sel_log.size() && i < 32; i++)
        chk($sformatf("sel_%0d", i), sel_log[i], i);
    end
  endtask

  task automatic check_bytes(input int base, input int err_base);
    logic [7:0] exp;
    chk("byte_count", rx_q.size() - base, WORDS * 4);
    chk("frame_err", frame_err - err_base, 0);
    for (int i = 0; i < WORDS * 4 && base + i < rx_q.size(); i++) begin
      if (i / 4 == 32) exp = PC_VAL[31 - 8 * (i % 4) -: 8];
      else if (i % 4 == 0) exp = 8'h10;
      else if (i % 4 == 3) exp = 8'(i / 4);
      else exp = 8'h00;
      chk($sformatf("byte_%0d", i), {24'd0, rx_q[base + i]}, {24'd0, exp});
    end
  endtask

  initial begin
    int base;
    int err_base;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sel", {27'd0, dbg_sel}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {31'd0, busy}, 32'd0);

    // Plain dump: length, done, byte stream, select sequence.
    base = rx_q.size();
    err_base = frame_err;
    run_dump(-1, -1, 1'b1);
    repeat (4) @(negedge clk);
    check_bytes(base, err_base);

    // start re-pulsed mid-dump is ignored.
    base = rx_q.size();
    err_base = frame_err;
    run_dump(100, -1, 1'b0);
    repeat (4) @(negedge clk);
    chk("after_repulse_busy", {31'd0, busy}, 32'd0);
    check_bytes(base, err_base);

    // Reset mid-dump aborts; the next dump is complete and clean.
    run_dump(-1, 300, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_abort_busy", {31'd0, busy}, 32'd0);
    chk("post_abort_tx", {31'd0, tx}, 32'd1);
    base = rx_q.size();
    err_base = frame_err;
    run_dump(-1, -1, 1'b1);
    repeat (4) @(negedge clk);
    check_bytes(base, err_base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
